// File: rtl/nbcac_pkg.sv
// -----------------------------------------------------------------------------
// nbcac_pkg
// Shared definitions for the sequential NBCAC (Fibonacci-weighted,
// no-forbidden-transition) encoder:
//   fib(n)                  Fibonacci number, F(1)=F(2)=1
//   nbcac_weight(code_w, k) weight of code bit d[k] (k = 1..code_w)
//   nbcac_capacity(code_w)  number of encodable input values, 2*F(code_w+1)
//   nbcac_state_e           encoder FSM state encoding (IDLE/RUN/DONE)
// No ports (package).
// -----------------------------------------------------------------------------
package nbcac_pkg;

   typedef enum logic [1:0] {
      NBCAC_IDLE = 2'd0,
      NBCAC_RUN  = 2'd1,
      NBCAC_DONE = 2'd2
   } nbcac_state_e;

   // Iterative Fibonacci, usable as an elaboration-time constant function.
   function automatic logic [63:0] fib(input int n);
      logic [63:0] f_a;
      logic [63:0] f_b;
      logic [63:0] f_t;
      f_a = 64'd0;
      f_b = 64'd1;
      for (int i = 2; i <= n; i++) begin
         f_t = f_a + f_b;
         f_a = f_b;
         f_b = f_t;
      end
      return (n <= 0) ? 64'd0 : f_b;
   endfunction

   // w1 = 1 carries the parity bit; the rest are doubled Fibonacci numbers.
   function automatic logic [63:0] nbcac_weight(input int code_w, input int k);
      return (k == 1) ? 64'd1 : (fib(code_w + 1 - k) << 1);
   endfunction

   function automatic logic [63:0] nbcac_capacity(input int code_w);
      return fib(code_w + 1) << 1;
   endfunction

endpackage

// File: rtl/nbcac_stage.sv
// -----------------------------------------------------------------------------
// nbcac_stage
// One link of the greedy weighted-subtraction chain (combinational).
// Ports:
//   i_r       residual entering this bit position
//   i_wk      weight of this bit, w(k)
//   i_wk1     weight of the next bit, w(k+1)
//   i_d_prev  code bit d(k-1)
//   i_last    this is the final bit d(CODE_W)
//   o_d       resolved code bit d(k)
//   o_r_next  residual after subtracting w(k)*d(k)
// -----------------------------------------------------------------------------
module nbcac_stage
   import nbcac_pkg::*;
#(
   parameter int W = 19
) (
   input  logic [W-1:0] i_r,
   input  logic [W-1:0] i_wk,
   input  logic [W-1:0] i_wk1,
   input  logic         i_d_prev,
   input  logic         i_last,
   output logic         o_d,
   output logic [W-1:0] o_r_next
);

   // One extra bit so the pair sum cannot wrap.
   logic [W:0] w_pair;

   assign w_pair = {1'b0, i_wk} + {1'b0, i_wk1};

   // Bit decision: forced 1, forced 0, or copy the neighbour so that
   // isolated 010/101 patterns never appear.
   always_comb begin
      if (i_last) begin
         o_d = (i_r != '0);
      end else if ({1'b0, i_r} >= w_pair) begin
         o_d = 1'b1;
      end else if (i_r < i_wk) begin
         o_d = 1'b0;
      end else begin
         o_d = i_d_prev;
      end
   end

   assign o_r_next = o_d ? (i_r - i_wk) : i_r;

endmodule

// File: rtl/nbcac_encoder_seq.sv
// -----------------------------------------------------------------------------
// nbcac_encoder_seq
// Multi-cycle NBCAC encoder: maps a DATA_W-bit word to a CODE_W-bit
// no-forbidden-transition codeword, resolving BITS_PER_CYC code bits per
// clock through a chain of nbcac_stage instances.
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   in_valid   / in_ready / in_data    input word handshake
//   out_valid  / out_ready / out_code  codeword handshake (out_code[k-1]=d[k])
//   out_err    input word was outside the codebook
// Build option:
//   NBCAC_RANGE_CHK_EN  when defined, words >= 2*F(CODE_W+1) raise out_err and
//                       have d[CODE_W] forced to 1; otherwise out_err is 0.
// -----------------------------------------------------------------------------
module nbcac_encoder_seq
   import nbcac_pkg::*;
#(
   parameter int DATA_W       = 18,
   parameter int CODE_W       = 26,
   parameter int BITS_PER_CYC = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CODE_W-1:0] out_code,
   output logic              out_err
);

   localparam int RW   = DATA_W + 1;
   localparam int SW   = $clog2(CODE_W + BITS_PER_CYC + 2);
   localparam int WT_N = 1 << SW;
   // The residual stays below 2^DATA_W, so weights can be clipped here
   // without changing any compare outcome.
   localparam logic [63:0] WT_MAX = (64'd1 << RW) - 64'd1;

   localparam logic [1:0] ST_IDLE = NBCAC_IDLE;
   localparam logic [1:0] ST_RUN  = NBCAC_RUN;
   localparam logic [1:0] ST_DONE = NBCAC_DONE;

   logic [1:0]        r_state;
   logic [RW-1:0]     r_res;
   logic [SW-1:0]     r_step;
   logic [CODE_W-1:0] r_code;
   logic              r_err;
   logic              r_out_valid;

   logic [RW-1:0]     w_wt   [WT_N];
   logic [SW-1:0]     w_k    [BITS_PER_CYC];
   logic              w_act  [BITS_PER_CYC];
   logic [RW-1:0]     w_r    [BITS_PER_CYC+1];
   logic              w_dp   [BITS_PER_CYC];
   logic              w_d    [BITS_PER_CYC];
   logic [RW-1:0]     w_rn   [BITS_PER_CYC];
   logic              w_dp0;
   logic [CODE_W-1:0] w_code_nx;
   logic              w_last_step;
   logic              w_accept;
   logic [RW-1:0]     w_load_res;
   logic [CODE_W-1:0] w_load_code;
   logic              w_load_err;

   // Weight table indexed by bit position k; entries outside 1..CODE_W are
   // zero so the w(k+1) lookup of the final bit is harmless.
   for (genvar gk = 0; gk < WT_N; gk++) begin : g_wt
      localparam logic [63:0] WF = ((gk >= 1) && (gk <= CODE_W)) ?
                                   nbcac_weight(CODE_W, gk) : 64'd0;
      assign w_wt[gk] = (WF > WT_MAX) ? WT_MAX[RW-1:0] : WF[RW-1:0];
   end

   assign w_r[0] = r_res;

   // Stage j resolves bit k = step + j; stages past CODE_W pass the residual.
   for (genvar gj = 0; gj < BITS_PER_CYC; gj++) begin : g_stage
      assign w_k[gj]   = r_step + SW'(gj);
      assign w_act[gj] = (w_k[gj] <= SW'(CODE_W));

      if (gj == 0) begin : g_first
         assign w_dp[gj] = w_dp0;
      end else begin : g_next
         assign w_dp[gj] = w_d[gj-1];
      end

      nbcac_stage #(.W(RW)) u_stage (
         .i_r      (w_r[gj]),
         .i_wk     (w_wt[w_k[gj]]),
         .i_wk1    (w_wt[w_k[gj] + SW'(1)]),
         .i_d_prev (w_dp[gj]),
         .i_last   (w_k[gj] == SW'(CODE_W)),
         .o_d      (w_d[gj]),
         .o_r_next (w_rn[gj])
      );

      assign w_r[gj+1] = w_act[gj] ? w_rn[gj] : w_r[gj];
   end

   // d(step-1): the already-resolved bit feeding the first stage.
   always_comb begin
      w_dp0 = 1'b0;
      for (int b = 0; b < CODE_W; b++) begin
         w_dp0 = (r_step == SW'(b + 2)) ? r_code[b] : w_dp0;
      end
   end

   // Merge this cycle's resolved bits into the code register image.
   always_comb begin
      w_code_nx = r_code;
      for (int b = 0; b < CODE_W; b++) begin
         for (int j = 0; j < BITS_PER_CYC; j++) begin
            if (w_act[j] && (w_k[j] == SW'(b + 1))) begin
               w_code_nx[b] = (b == CODE_W - 1) ? (w_d[j] | r_err) : w_d[j];
            end else begin
               w_code_nx[b] = w_code_nx[b];
            end
         end
      end
   end

   assign w_last_step = (w_k[BITS_PER_CYC-1] >= SW'(CODE_W));

   assign in_ready = rst_n & ((r_state == ST_IDLE) |
                              ((r_state == ST_DONE) & out_ready));
   assign w_accept = in_valid & in_ready;

   // Load image: d1 is the parity bit, the residual is the even remainder.
   assign w_load_res  = {1'b0, in_data} - {{DATA_W{1'b0}}, in_data[0]};
   assign w_load_code = {{(CODE_W-1){1'b0}}, in_data[0]};

`ifdef NBCAC_RANGE_CHK_EN
   assign w_load_err = (64'(in_data) >= nbcac_capacity(CODE_W));
`else
   assign w_load_err = 1'b0;
`endif

   // Encoder FSM and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_res       <= '0;
         r_step      <= '0;
         r_code      <= '0;
         r_err       <= 1'b0;
         r_out_valid <= 1'b0;
      end else if (w_accept) begin
         // Covers both IDLE and the DONE handshake cycle (no bubble).
         r_state     <= ST_RUN;
         r_res       <= w_load_res;
         r_step      <= SW'(2);
         r_code      <= w_load_code;
         r_err       <= w_load_err;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_state <= ST_IDLE;
            end
            ST_RUN: begin
               r_res  <= w_r[BITS_PER_CYC];
               r_step <= r_step + SW'(BITS_PER_CYC);
               r_code <= w_code_nx;
               if (w_last_step) begin
                  r_state     <= ST_DONE;
                  r_out_valid <= 1'b1;
               end else begin
                  r_state <= ST_RUN;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state     <= ST_IDLE;
                  r_out_valid <= 1'b0;
               end else begin
                  r_state <= ST_DONE;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign out_code  = r_code;
   assign out_err   = r_err;

endmodule
